// File: rtl/serial_pkg.sv
//------------------------------------------------------------------------------
// serial_pkg : shared state encoding and defaults for the serial word framer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package serial_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ST_W       = 3;

  typedef enum logic [ST_W-1:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    GAP    = 3'd4
  } state_t;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_timer.sv
//------------------------------------------------------------------------------
// bit_timer : BIT_CYCLES divider with a registered bit_end pulse on each bit's last clock
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bit_timer
  import serial_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_run_nxt,
  output logic o_bit_end,
  output logic o_bit_end_nxt
);

  localparam int               CNT_W  = clog2_min1(BIT_CYCLES);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_bit_end;

  always_comb begin
    w_cnt_nxt = '0;
    if (i_run && (r_cnt != C_LAST)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // Look one clock ahead so the pulse itself can come straight from a flop.
  assign o_bit_end_nxt = i_run_nxt && (w_cnt_nxt == C_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_bit_end <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_bit_end <= o_bit_end_nxt;
    end
  end

  assign o_bit_end = r_bit_end;

endmodule

`default_nettype wire

// File: rtl/serial_word_tx.sv
//------------------------------------------------------------------------------
// serial_word_tx : parallel-to-serial framer (start '1', data MSB-first, idle '0' gap)
// Optional even-parity bit after the data with `define SERIAL_TX_PARITY_EN. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_word_tx
  import serial_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int BIT_CYCLES = 1,
  parameter int IDLE_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              so,
  output logic              bit_stb,
  output logic              frame_start,
  output logic              frame_done
);

  localparam int                BCNT_W     = $clog2(DATA_W + 1);
  localparam logic [BCNT_W-1:0] C_LAST_BIT = BCNT_W'(DATA_W - 1);
  localparam int                GCNT_W     = clog2_min1(IDLE_BITS);
  localparam logic [GCNT_W-1:0] C_LAST_GAP = GCNT_W'(IDLE_BITS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_sreg;
  logic [DATA_W-1:0]   w_sreg_nxt;
  logic [BCNT_W-1:0]   r_bitcnt;
  logic [BCNT_W-1:0]   w_bitcnt_nxt;
  logic [GCNT_W-1:0]   r_gapcnt;
  logic [GCNT_W-1:0]   w_gapcnt_nxt;

  logic r_in_ready;
  logic r_so;
  logic r_bit_stb;
  logic r_frame_start;
  logic r_frame_done;

  logic w_accept;
  logic w_run;
  logic w_run_nxt;
  logic w_bit_end;
  logic w_bit_end_nxt;
  logic w_last_data;
  logic w_so_nxt;
  logic w_stb_nxt;
  logic w_done_nxt;

`ifdef SERIAL_TX_PARITY_EN
  logic r_par;
  logic w_par_nxt;
`endif

  assign w_accept    = in_valid && r_in_ready;
  assign w_run       = (r_state != IDLE);
  assign w_run_nxt   = (w_state_nxt != IDLE);
  assign w_last_data = (r_bitcnt == C_LAST_BIT);

  bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk           (clk),
    .rst           (rst),
    .i_run         (w_run),
    .i_run_nxt     (w_run_nxt),
    .o_bit_end     (w_bit_end),
    .o_bit_end_nxt (w_bit_end_nxt)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_sreg_nxt   = r_sreg;
    w_bitcnt_nxt = r_bitcnt;
    w_gapcnt_nxt = r_gapcnt;
`ifdef SERIAL_TX_PARITY_EN
    w_par_nxt    = r_par;
`endif
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt  = START;
          w_sreg_nxt   = in_data;
          w_bitcnt_nxt = '0;
          w_gapcnt_nxt = '0;
`ifdef SERIAL_TX_PARITY_EN
          w_par_nxt    = ^in_data;
`endif
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_sreg_nxt   = {r_sreg[DATA_W-2:0], 1'b0};
          w_bitcnt_nxt = r_bitcnt + 1'b1;
          if (w_last_data) begin
`ifdef SERIAL_TX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = GAP;
`endif
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = GAP;
        end
      end
`endif
      GAP: begin
        if (w_bit_end) begin
          if (r_gapcnt == C_LAST_GAP) begin
            w_state_nxt = IDLE;
          end else begin
            w_gapcnt_nxt = r_gapcnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output values are decoded from the next state so every output is a flop.
  always_comb begin
    w_so_nxt = 1'b0;
    case (w_state_nxt)
      START:   w_so_nxt = 1'b1;
      DATA:    w_so_nxt = w_sreg_nxt[DATA_W-1];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  w_so_nxt = w_par_nxt;
`endif
      default: w_so_nxt = 1'b0;
    endcase
  end

`ifdef SERIAL_TX_PARITY_EN
  assign w_stb_nxt  = w_bit_end_nxt && ((w_state_nxt == DATA) || (w_state_nxt == PARITY));
  assign w_done_nxt = w_bit_end_nxt && (w_state_nxt == PARITY);
`else
  assign w_stb_nxt  = w_bit_end_nxt && (w_state_nxt == DATA);
  assign w_done_nxt = w_bit_end_nxt && (w_state_nxt == DATA) && (w_bitcnt_nxt == C_LAST_BIT);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_sreg   <= '0;
      r_bitcnt <= '0;
      r_gapcnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sreg   <= w_sreg_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_gapcnt <= w_gapcnt_nxt;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par <= 1'b0;
    end else begin
      r_par <= w_par_nxt;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_ready    <= 1'b1;
      r_so          <= 1'b0;
      r_bit_stb     <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_in_ready    <= (w_state_nxt == IDLE);
      r_so          <= w_so_nxt;
      r_bit_stb     <= w_stb_nxt;
      r_frame_start <= w_accept;
      r_frame_done  <= w_done_nxt;
    end
  end

  assign in_ready    = r_in_ready;
  assign so          = r_so;
  assign bit_stb     = r_bit_stb;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;

endmodule

`default_nettype wire
